// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage RV32I pipeline.
// It captures decode controls and operands for EX. It detects load-use
// hazards, inserts a bubble and raises stall_o for exactly one cycle.
// A taken branch/jump resolved in EX (flush_i) turns the capture into a bubble.
// Optional feature macro: HAZARD_STATS_EN adds the stall_cnt/flush_cnt outputs.
module id_ex_stage #(
    parameter int          XLEN    = 32,
    parameter logic [1:0]  WD_DRAM = 2'b01,
    parameter logic [6:0]  OPC_LUI = 7'b0110111,
    parameter logic [6:0]  OPC_JAL = 7'b1101111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_pc_sel,
    input  logic            id_npc_op,
    input  logic            id_rf_we,
    input  logic            id_alub_sel,
    input  logic            id_dram_we,
    input  logic [1:0]      id_wd_sel,
    input  logic [3:0]      id_alu_op,
    input  logic            flush_i,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_pc_sel,
    output logic            ex_npc_op,
    output logic            ex_rf_we,
    output logic            ex_alub_sel,
    output logic            ex_dram_we,
    output logic [1:0]      ex_wd_sel,
    output logic [3:0]      ex_alu_op,
    output logic            stall_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    // Instruction fields
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic [6:0] id_opcode;
    logic       unused_funct7;

    assign id_rs1        = id_inst[19:15];
    assign id_rs2        = id_inst[24:20];
    assign id_rd         = id_inst[11:7];
    assign id_opcode     = id_inst[6:0];
    assign unused_funct7 = ^id_inst[31:25];

    // Pipeline state
    logic            ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0] ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0] ex_rd1_q,      ex_rd1_d;
    logic [XLEN-1:0] ex_rd2_q,      ex_rd2_d;
    logic [XLEN-1:0] ex_imm_q,      ex_imm_d;
    logic [4:0]      ex_rs1_q,      ex_rs1_d;
    logic [4:0]      ex_rs2_q,      ex_rs2_d;
    logic [4:0]      ex_rd_q,       ex_rd_d;
    logic            ex_pc_sel_q,   ex_pc_sel_d;
    logic            ex_npc_op_q,   ex_npc_op_d;
    logic            ex_rf_we_q,    ex_rf_we_d;
    logic            ex_alub_sel_q, ex_alub_sel_d;
    logic            ex_dram_we_q,  ex_dram_we_d;
    logic [1:0]      ex_wd_sel_q,   ex_wd_sel_d;
    logic [3:0]      ex_alu_op_q,   ex_alu_op_d;

    logic uses_rs1;
    logic uses_rs2;
    logic hazard;

    // Load-use detection: a load in EX whose destination feeds a source read by ID
    always_comb begin
        uses_rs1 = (id_opcode != OPC_LUI) && (id_opcode != OPC_JAL);
        uses_rs2 = (id_opcode == 7'b0110011) || (id_opcode == 7'b0100011) ||
                   (id_opcode == 7'b1100011);
        hazard   = ex_valid_q && id_valid && ex_rf_we_q &&
                   (ex_wd_sel_q == WD_DRAM) && (ex_rd_q != 5'd0) &&
                   ((uses_rs1 && (ex_rd_q == id_rs1)) ||
                    (uses_rs2 && (ex_rd_q == id_rs2)));
        // A flush kills the ID instruction upstream too, so no stall is needed
        stall_o  = hazard && !flush_i && rst_n;
    end

    // Next EX contents: bubble on flush or hazard, otherwise capture ID
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_rd1_d      = '0;
        ex_rd2_d      = '0;
        ex_imm_d      = '0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_rd_d       = '0;
        ex_pc_sel_d   = 1'b0;
        ex_npc_op_d   = 1'b0;
        ex_rf_we_d    = 1'b0;
        ex_alub_sel_d = 1'b0;
        ex_dram_we_d  = 1'b0;
        ex_wd_sel_d   = '0;
        ex_alu_op_d   = '0;
        if (!flush_i && !hazard) begin
            ex_valid_d = id_valid;
            ex_pc_d    = id_pc;
            ex_rd1_d   = id_rd1;
            ex_rd2_d   = id_rd2;
            ex_imm_d   = id_imm;
            ex_rs1_d   = id_rs1;
            ex_rs2_d   = id_rs2;
            ex_rd_d    = id_rd;
            // Controls of a non-instruction stay zero so it can never write RF/DRAM
            if (id_valid) begin
                ex_pc_sel_d   = id_pc_sel;
                ex_npc_op_d   = id_npc_op;
                ex_rf_we_d    = id_rf_we;
                ex_alub_sel_d = id_alub_sel;
                ex_dram_we_d  = id_dram_we;
                ex_wd_sel_d   = id_wd_sel;
                ex_alu_op_d   = id_alu_op;
            end
        end
    end

    // ID/EX register with synchronous active-low reset to a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rd1_q      <= '0;
            ex_rd2_q      <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_pc_sel_q   <= 1'b0;
            ex_npc_op_q   <= 1'b0;
            ex_rf_we_q    <= 1'b0;
            ex_alub_sel_q <= 1'b0;
            ex_dram_we_q  <= 1'b0;
            ex_wd_sel_q   <= '0;
            ex_alu_op_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rd1_q      <= ex_rd1_d;
            ex_rd2_q      <= ex_rd2_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_pc_sel_q   <= ex_pc_sel_d;
            ex_npc_op_q   <= ex_npc_op_d;
            ex_rf_we_q    <= ex_rf_we_d;
            ex_alub_sel_q <= ex_alub_sel_d;
            ex_dram_we_q  <= ex_dram_we_d;
            ex_wd_sel_q   <= ex_wd_sel_d;
            ex_alu_op_q   <= ex_alu_op_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rd1      = ex_rd1_q;
    assign ex_rd2      = ex_rd2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rs1      = ex_rs1_q;
    assign ex_rs2      = ex_rs2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_pc_sel   = ex_pc_sel_q;
    assign ex_npc_op   = ex_npc_op_q;
    assign ex_rf_we    = ex_rf_we_q;
    assign ex_alub_sel = ex_alub_sel_q;
    assign ex_dram_we  = ex_dram_we_q;
    assign ex_wd_sel   = ex_wd_sel_q;
    assign ex_alu_op   = ex_alu_op_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters, wrapping naturally at 2^32
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register of the five-stage RV32I pipeline, placed directly downstream of the decode control unit. It captures that unit's control outputs and the decode-stage operands each cycle for use by EX. It also detects load-use hazards, inserting a bubble and stalling PC and IF/ID. A taken branch or jump resolved in EX flushes it.

Parameters:
XLEN, 32, datapath width for pc, operands and immediate
WD_DRAM, 2'b01, wd_sel encoding meaning "write-back from data memory" (load)
OPC_LUI, 7'b0110111, opcode that reads no source register
OPC_JAL, 7'b1101111, opcode that reads no source register

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_inst  in  32  ID instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0]
id_pc  in  XLEN  ID instruction address
id_rd1  in  XLEN  register-file read data 1
id_rd2  in  XLEN  register-file read data 2
id_imm  in  XLEN  sign-extended immediate
id_pc_sel, id_npc_op, id_rf_we, id_alub_sel, id_dram_we  in  1 each  decode controls
id_wd_sel  in  2  write-back select
id_alu_op  in  4  ALU operation
flush_i  in  1  taken branch/jump resolved in EX this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered operands
ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
ex_pc_sel, ex_npc_op, ex_rf_we, ex_alub_sel, ex_dram_we  out  1 each  registered controls
ex_wd_sel  out  2  registered write-back select
ex_alu_op  out  4  registered ALU operation
stall_o  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (rst_n low at posedge): all ex_* outputs 0 (ex_valid=0), i.e. a bubble. stall_o is 0 while rst_n is low. Hazard counters (if enabled) cleared.
- uses_rs1 = opcode not OPC_LUI and not OPC_JAL.
- uses_rs2 = opcode in {0110011 R, 0100011 S, 1100011 B}.
- hazard = ex_valid & id_valid & ex_rf_we & (ex_wd_sel==WD_DRAM) & (ex_rd!=0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- stall_o = hazard & ~flush_i & rst_n. Combinational, same cycle.
- Per-posedge priority: reset > flush_i > hazard > normal load.
  - flush_i=1: load bubble. All control bits 0 (rf_we=0, dram_we=0, pc_sel=0, npc_op=0) and ex_valid=0. Data fields are don't-care; the implementation zeroes them.
  - hazard (no flush): load bubble as above. Upstream holds, so the same ID instruction is re-presented next cycle. That cycle's hazard check uses the bubble (ex_valid=0) and fails, so the stall lasts exactly 1 cycle.
  - otherwise: ex_* <= id_*, and ex_valid <= id_valid. When id_valid=0, all controls are forced to 0 so a bubble never writes RF or DRAM.
- Latency 1 cycle ID->EX. Full throughput when no hazard or flush.
- Simultaneous flush and hazard: flush wins and stall_o=0, because the ID instruction is also being killed upstream.
- rd=x0 never raises a hazard.
- Back-to-back loads whose rd feeds the next instruction each stall exactly 1 cycle.
- rst_n asserted mid-stall: next cycle is a bubble and stall_o drops immediately.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each posedge where stall_o=1.
  - flush_cnt increments on each posedge where flush_i=1 and rst_n=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3, pc=0x10, valid) -> next cycle ex_rd=3, ex_rf_we=1, ex_wd_sel=id value, ex_valid=1, stall_o=0 throughout.
- LW x5,0(x1) in EX (wd_sel=WD_DRAM, rf_we=1) with ADD x6,x5,x2 in ID -> stall_o=1 for one cycle, then bubble (ex_valid=0, ex_rf_we=0); next cycle ADD reaches EX and stall_o=0.
- LW x0,0(x1) followed by ADD x6,x0,x2 -> stall_o never asserted.
- LW x5 followed by LUI x5,0x12345 -> no stall (LUI uses no rs). LW x5 followed by SW x5,4(x1) -> stall (rs2 match).
- flush_i=1 coincident with a load-use hazard -> stall_o=0, EX receives a bubble with dram_we=0 and rf_we=0.
- HAZARD_STATS_EN: three load-use pairs and two flushes -> stall_cnt=3, flush_cnt=2. Reset -> both 0.
